vga_fb_fill: RTL
================

VGA_FB_FILL -- requirements
Module: vga_fb_fill

Interface
REQ-001 Parameter H_RES, default 320, framebuffer width in pixels.
REQ-002 Parameter V_RES, default 240, framebuffer height in pixels.
REQ-003 CLK_50MHz  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  command strobe; sampled only in IDLE.
REQ-006 ABORT  input  1  cancel the fill in progress.
REQ-007 X0, X1  input  9  corner column coordinates.
REQ-008 Y0, Y1  input  8  corner row coordinates.
REQ-009 COLOR  input  12  fill color {R[11:8],G[7:4],B[3:0]}.
REQ-010 WA  output  17  framebuffer write address, registered.
REQ-011 WD  output  12  framebuffer write data, registered.
REQ-012 WE  output  1  framebuffer write enable, registered; one pixel per cycle high.
REQ-013 BUSY  output  1  fill in progress.
REQ-014 DONE  output  1  one-cycle pulse on normal completion.
REQ-015 ERR  output  1  one-cycle pulse on rejected command.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, FINISH.
REQ-017 In IDLE with START=1, the block SHALL latch COLOR and the corners as xlo=min(X0,X1), xhi=max(X0,X1), ylo=min(Y0,Y1), yhi=max(Y0,Y1).
REQ-018 If xhi>=H_RES or yhi>=V_RES at START, the block SHALL assert ERR for exactly the next cycle, issue no writes, keep BUSY=0 and remain in IDLE.
REQ-019 For a valid START sampled at edge k, the first write SHALL be visible after edge k+1: WE=1, WA=ylo*H_RES+xlo, WD=COLOR.
REQ-020 In FILL, pixels SHALL be written row-major, one per cycle, with no gaps: column xlo..xhi within each row, rows ylo..yhi.
REQ-021 WA SHALL equal row*H_RES+col computed at full 17-bit width without truncation; for the default parameters, the maximum value is 76799.
REQ-022 The total number of WE=1 cycles per valid command SHALL be exactly (xhi-xlo+1)*(yhi-ylo+1).
REQ-023 BUSY SHALL be 1 in every cycle where WE=1 and 0 otherwise.
REQ-024 After the last pixel write, the FSM SHALL enter FINISH for one cycle with DONE=1, WE=0 and BUSY=0, then return to IDLE.
REQ-025 START SHALL be ignored in FILL and FINISH; a command is only accepted in IDLE.
REQ-026 Changes on X0, X1, Y0, Y1 and COLOR SHALL NOT affect an in-progress fill.
REQ-027 ABORT=1 sampled in FILL SHALL force WE=0 and BUSY=0 after that edge and return the FSM to IDLE, without a DONE pulse.
REQ-028 ABORT=1 sampled in IDLE or FINISH SHALL have no effect.
REQ-029 When START and ABORT are both 1 in IDLE, START SHALL take effect.
REQ-030 When WE=0, WA and WD SHALL hold their last values.

Reset
REQ-031 With RST=1 sampled, on the next cycle the block SHALL be in IDLE with WA=0, WD=0, WE=0, BUSY=0, DONE=0, ERR=0.
REQ-032 RST SHALL take priority over START and ABORT in all states.
REQ-033 RST asserted during FILL SHALL stop writes on the next cycle, with no DONE pulse.

Verification
REQ-034 Single pixel, (5,3)-(5,3), COLOR=0xF00 -> exactly one write at WA=965 with WD=0xF00, followed by DONE=1 on the next cycle.
REQ-035 Rectangle (0,0)-(2,1) -> WA=0,1,2,320,321,322 on six consecutive cycles; BUSY high for 6 cycles; DONE on the 7th cycle.
REQ-036 Swapped corners, X0=2 Y0=1 X1=0 Y1=0 -> a write sequence identical to REQ-035.
REQ-037 Full screen (0,0)-(319,239) -> 76800 writes; last WA=76799; DONE follows.
REQ-038 Out-of-range command X1=320 -> ERR=1 for one cycle; WE, BUSY and DONE stay 0.
REQ-039 ABORT after the third write of REQ-035 -> only WA=0,1,2 written and no DONE; a subsequent START is accepted normally. RST mid-fill -> WE=0 on the next cycle.

Source files
------------

// File: rtl/vga_fb_fill.sv
// vga_fb_fill: fills an axis-aligned rectangle of a framebuffer with one
// color. It writes one pixel per cycle in row-major order and drives a simple
// registered write port (WA/WD/WE). Pixel addresses are tracked
// incrementally, so only the first address of a command needs a multiply.
module vga_fb_fill #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic        CLK_50MHz,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [8:0]  X0,
  input  logic [8:0]  X1,
  input  logic [7:0]  Y0,
  input  logic [7:0]  Y1,
  input  logic [11:0] COLOR,
  output logic [16:0] WA,
  output logic [11:0] WD,
  output logic        WE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [16:0] H_STEP = 17'(H_RES);
  localparam logic [31:0] H_LIM  = 32'(H_RES);
  localparam logic [31:0] V_LIM  = 32'(V_RES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  xlo_q, xlo_d, xhi_q, xhi_d, col_q, col_d;
  logic [7:0]  yhi_q, yhi_d, row_q, row_d;
  logic [11:0] color_q, color_d;
  logic [16:0] addr_q, addr_d;       // address of the next pixel to write
  logic [16:0] rowbase_q, rowbase_d; // address of column 0 of the current row
  logic        last_q, last_d;       // final pixel already issued
  logic [16:0] wa_q, wa_d;
  logic [11:0] wd_q, wd_d;
  logic        we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  // Normalised corners of the command currently on the inputs.
  logic [8:0]  x_lo_s, x_hi_s;
  logic [7:0]  y_lo_s, y_hi_s;
  logic        cmd_ok_s;
  logic [16:0] base_s, first_addr_s, next_base_s;

  assign x_lo_s       = (X0 < X1) ? X0 : X1;
  assign x_hi_s       = (X0 < X1) ? X1 : X0;
  assign y_lo_s       = (Y0 < Y1) ? Y0 : Y1;
  assign y_hi_s       = (Y0 < Y1) ? Y1 : Y0;
  assign cmd_ok_s     = ({23'd0, x_hi_s} < H_LIM) && ({24'd0, y_hi_s} < V_LIM);
  assign base_s       = {9'd0, y_lo_s} * H_STEP;
  assign first_addr_s = base_s + {8'd0, x_lo_s};
  assign next_base_s  = rowbase_q + H_STEP;

  // Next-state and next-output logic; pulses and write strobes default low.
  always_comb begin
    state_d   = state_q;
    xlo_d     = xlo_q;
    xhi_d     = xhi_q;
    yhi_d     = yhi_q;
    col_d     = col_q;
    row_d     = row_q;
    color_d   = color_q;
    addr_d    = addr_q;
    rowbase_d = rowbase_q;
    last_d    = last_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    we_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (cmd_ok_s) begin
            xlo_d     = x_lo_s;
            xhi_d     = x_hi_s;
            yhi_d     = y_hi_s;
            col_d     = x_lo_s;
            row_d     = y_lo_s;
            color_d   = COLOR;
            rowbase_d = base_s;
            addr_d    = first_addr_s;
            last_d    = 1'b0;
            state_d   = FILL;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (last_q) begin
          // The cycle after the final write shows DONE while in FINISH.
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          wa_d   = addr_q;
          wd_d   = color_q;
          if (col_q == xhi_q) begin
            if (row_q == yhi_q) begin
              last_d = 1'b1;
            end else begin
              row_d     = row_q + 8'd1;
              col_d     = xlo_q;
              rowbase_d = next_base_s;
              addr_d    = next_base_s + {8'd0, xlo_q};
            end
          end else begin
            col_d  = col_q + 9'd1;
            addr_d = addr_q + 17'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset taking priority.
  always_ff @(posedge CLK_50MHz) begin
    if (RST) begin
      state_q   <= IDLE;
      xlo_q     <= 9'd0;
      xhi_q     <= 9'd0;
      yhi_q     <= 8'd0;
      col_q     <= 9'd0;
      row_q     <= 8'd0;
      color_q   <= 12'd0;
      addr_q    <= 17'd0;
      rowbase_q <= 17'd0;
      last_q    <= 1'b0;
      wa_q      <= 17'd0;
      wd_q      <= 12'd0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      xlo_q     <= xlo_d;
      xhi_q     <= xhi_d;
      yhi_q     <= yhi_d;
      col_q     <= col_d;
      row_q     <= row_d;
      color_q   <= color_d;
      addr_q    <= addr_d;
      rowbase_q <= rowbase_d;
      last_q    <= last_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign WA   = wa_q;
  assign WD   = wd_q;
  assign WE   = we_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule
